// File: rtl/uart_tx_buf.sv
// uart_tx_buf: FIFO-buffered UART transmitter, 8N1 frames sent LSB first.
// Define UART_TX_PARITY_EN to add an even parity bit after D7 (8E1 frames).
module uart_tx_buf #(
    parameter int BAUD_DIV = 2604,
    parameter int FIFO_AW  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       tx
);
    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        baud_cnt_q, baud_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         mem_d [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif
    logic               push;
    logic               pop;
    logic               bit_done;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign busy     = (state_q != S_IDLE) | ~empty;
    assign tx       = tx_q;
    assign bit_done = (baud_cnt_q == BAUD_LAST);
    assign push     = wr_en & ~full;

    // Frame sequencer; tx_d follows the next state so the line is registered.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 16'd1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    state_d    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                baud_cnt_d = '0;
                state_d    = S_IDLE;
            end
        endcase

        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            parity_d = ^mem_q[rd_ptr_q];
`endif
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // A write while full is dropped even if a pop frees a slot on the same edge.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
        end
        wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
        rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
        count_d  = count_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            mem_q      <= '{default: 8'h00};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end
endmodule
